// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the mips32 hazard controller: MDU wait FSM states and register constants.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } mdu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_mdu_busy_timer.sv
// Tracks the in-flight mult/div op: RUN/MDU_WAIT FSM plus a down-counter reloaded on every start.
module mdu_busy_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start always reloads, so back-to-back ops extend the wait instead of ending it early.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (start) begin
          state_d = ST_MDU_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_MDU_WAIT: begin
        if (start) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // busy is the FSM state itself and doubles as its observable state.
  assign busy = (state_q == ST_MDU_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, taken-branch and MDU-busy stall/flush control
// for PC, IF_ID and ID_EX, plus a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_uses_hilo,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mdu_start,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles
);

  logic        load_use;
  logic        mdu_haz;
  logic        busy;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  mdu_busy_timer #(
    .MDU_LATENCY(MDU_LATENCY),
    .CNT_W      (CNT_W)
  ) u_mdu_busy_timer (
    .clk  (clk),
    .rst  (rst),
    .start(mdu_start),
    .busy (busy)
  );

  assign mdu_busy = busy;

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  // A hilo reader must also wait when the op is only being issued this very cycle.
  assign mdu_haz = id_uses_hilo && (busy || mdu_start);

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use || mdu_haz) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MDU_LATENCY=4; inputs change on negedge, outputs checked 1ns later.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, id_uses_hilo;
  logic        ex_mem_read, ex_branch_taken, mdu_start;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy;
  logic [31:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MDU_LATENCY(4),
    .CNT_W      (6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_uses_hilo   (id_uses_hilo),
    .ex_mem_read    (ex_mem_read),
    .ex_rt          (ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .mdu_start      (mdu_start),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .mdu_busy       (mdu_busy),
    .stall_cycles   (stall_cycles)
  );

  task automatic drive_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_uses_hilo = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mdu_start = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL reset_pc_write got %b want 1", pc_write); end
    n_cmp++; if (if_id_write !== 1'b1) begin n_err++; $display("FAIL reset_if_id_write got %b want 1", if_id_write); end
    n_cmp++; if (if_id_flush !== 1'b0) begin n_err++; $display("FAIL reset_if_id_flush got %b want 0", if_id_flush); end
    n_cmp++; if (id_ex_flush !== 1'b0) begin n_err++; $display("FAIL reset_id_ex_flush got %b want 0", id_ex_flush); end
    n_cmp++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL reset_mdu_busy got %b want 0", mdu_busy); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    #1;
    n_cmp++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0001) begin
      n_err++; $display("FAIL load_use_rs got %b want 0001", {pc_write, if_id_write, if_id_flush, id_ex_flush});
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1100) begin
      n_err++; $display("FAIL load_use_release got %b want 1100", {pc_write, if_id_write, if_id_flush, id_ex_flush});
    end
    n_cmp++; if (stall_cycles !== 32'd1) begin n_err++; $display("FAIL load_use_count got %0d want 1", stall_cycles); end
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    #1;
    n_cmp++; if ({pc_write, if_id_write, id_ex_flush} !== 3'b001) begin
      n_err++; $display("FAIL load_use_rt got %b want 001", {pc_write, if_id_write, id_ex_flush});
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (stall_cycles !== 32'd2) begin n_err++; $display("FAIL load_use_rt_count got %0d want 2", stall_cycles); end
  endtask

  task automatic test_no_stall();
    apply_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #1;
    n_cmp++; if ({pc_write, if_id_write, id_ex_flush} !== 3'b110) begin
      n_err++; $display("FAIL no_stall_r0 got %b want 110", {pc_write, if_id_write, id_ex_flush});
    end
    ex_rt = 5'd7; id_rs = 5'd7; id_rt = 5'd7; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    #1;
    n_cmp++; if ({pc_write, if_id_write, id_ex_flush} !== 3'b110) begin
      n_err++; $display("FAIL no_stall_unused got %b want 110", {pc_write, if_id_write, id_ex_flush});
    end
    id_uses_rt = 1'b1; id_rt = 5'd8;
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL no_stall_mismatch got %b want 1", pc_write); end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL no_stall_count got %0d want 0", stall_cycles); end
  endtask

  task automatic test_branch();
    apply_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; ex_branch_taken = 1'b1;
    #1;
    n_cmp++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1111) begin
      n_err++; $display("FAIL branch_over_load got %b want 1111", {pc_write, if_id_write, if_id_flush, id_ex_flush});
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL branch_count got %0d want 0", stall_cycles); end
  endtask

  // mdu_start at cycle 0, hilo reader in ID from cycle 1.
  task automatic test_mdu_wait();
    logic exp_busy;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      mdu_start = (c == 0);
      id_uses_hilo = (c >= 1);
      #1;
      exp_busy = (c >= 1) && (c <= 3);
      n_cmp++; if (mdu_busy !== exp_busy) begin n_err++; $display("FAIL mdu_busy c%0d got %b want %b", c, mdu_busy, exp_busy); end
      n_cmp++; if (pc_write !== !exp_busy) begin n_err++; $display("FAIL mdu_pc_write c%0d got %b want %b", c, pc_write, !exp_busy); end
      n_cmp++; if (id_ex_flush !== exp_busy) begin n_err++; $display("FAIL mdu_id_ex_flush c%0d got %b want %b", c, id_ex_flush, exp_busy); end
      @(negedge clk);
    end
    drive_idle();
    #1;
    n_cmp++; if (stall_cycles !== 32'd3) begin n_err++; $display("FAIL mdu_count got %0d want 3", stall_cycles); end
  endtask

  // Second start at cycle 2; a taken branch mid-wait must not abort it.
  task automatic test_back_to_back();
    logic exp_busy;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      mdu_start = (c == 0) || (c == 2);
      ex_branch_taken = (c == 4);
      id_uses_hilo = (c >= 1);
      #1;
      exp_busy = (c >= 1) && (c <= 5);
      n_cmp++; if (mdu_busy !== exp_busy) begin n_err++; $display("FAIL b2b_busy c%0d got %b want %b", c, mdu_busy, exp_busy); end
      n_cmp++; if (pc_write !== (!exp_busy || c == 4)) begin
        n_err++; $display("FAIL b2b_pc_write c%0d got %b want %b", c, pc_write, (!exp_busy || c == 4));
      end
      @(negedge clk);
    end
    drive_idle();
    #1;
    n_cmp++; if (stall_cycles !== 32'd4) begin n_err++; $display("FAIL b2b_count got %0d want 4", stall_cycles); end
  endtask

  task automatic test_mdu_reset();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      mdu_start = (c == 0) || (c == 2);
      id_uses_hilo = (c >= 1);
      @(negedge clk);
    end
    mdu_start = 1'b0;
    #1;
    n_cmp++; if (mdu_busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy got %b want 1", mdu_busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", mdu_busy); end
    n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL rst_mid_pc_write got %b want 1", pc_write); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL rst_mid_count got %0d want 0", stall_cycles); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL rst_after_busy got %b want 0", mdu_busy); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_saturate();
    logic [31:0] exp_cnt;
    apply_reset();
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    exp_cnt = 32'hFFFF_FFFE;
    ex_mem_read = 1'b1; ex_rt = 5'd12; id_rt = 5'd12; id_uses_rt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      exp_cnt = 32'hFFFF_FFFF;
      n_cmp++; if (stall_cycles !== exp_cnt) begin n_err++; $display("FAIL sat_count c%0d got %h want %h", c, stall_cycles, exp_cnt); end
    end
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mdu_wait();
    test_back_to_back();
    test_mdu_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

endmodule
